// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Imported by the interface, the scoreboard and the arbiter top.
package rf_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of ALU, long-latency, issue, hazard and RF write-port signals.
// The arbiter sits on the slave side; the surrounding pipeline on master.
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic                  alu_we;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_wd;
    logic                  alu_stall;

    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [XLEN-1:0]       lu_wd;
    logic                  lu_ready;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic                  iss_ready;

    logic [REG_ADDR_W-1:0] chk_a1;
    logic [REG_ADDR_W-1:0] chk_a2;
    logic                  raw_hazard;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_a3;
    logic [XLEN-1:0]       rf_wd;

    logic                  err_waw;

    modport master (
        output alu_we, alu_rd, alu_wd,
        input  alu_stall,
        output lu_valid, lu_rd, lu_wd,
        input  lu_ready,
        output iss_valid, iss_rd,
        input  iss_ready,
        output chk_a1, chk_a2,
        input  raw_hazard,
        input  rf_we, rf_a3, rf_wd,
        input  err_waw
    );

    modport slave (
        input  alu_we, alu_rd, alu_wd,
        output alu_stall,
        input  lu_valid, lu_rd, lu_wd,
        output lu_ready,
        input  iss_valid, iss_rd,
        output iss_ready,
        input  chk_a1, chk_a2,
        output raw_hazard,
        output rf_we, rf_a3, rf_wd,
        output err_waw
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register busy bits for outstanding long-latency destinations.
// x0 is never tracked; a set and clear on one register in one edge -> set.
import rf_wb_arbiter_pkg::*;

module rf_scoreboard (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rd_a1,
    input  logic [REG_ADDR_W-1:0] rd_a2,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  busy_a1,
    output logic                  busy_a2,
    output logic                  iss_free,
    output logic [NUM_REGS-1:0]   busy
);

    assign busy_a1  = busy[rd_a1];
    assign busy_a2  = busy[rd_a2];
    assign iss_free = ~busy[iss_rd];

    // Busy vector update: clear first so a same-edge set takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (clr_en)
                busy[clr_addr] <= 1'b0;
            if (set_en && set_addr != ZERO_REG)
                busy[set_addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single RF write port shared by the ALU (priority) and a long-latency
// unit, with a starvation guard and a destination scoreboard.
import rf_wb_arbiter_pkg::*;

module rf_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    rf_wb_arbiter_if.slave bus
);

    localparam logic [3:0] CNT_LAST = 4'(MAX_WAIT - 1);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                rf_src_lu;
    logic [NUM_REGS-1:0] busy_vec;

    logic alu_req;
    logic alu_take;
    logic lu_ready;
    logic lu_write;
    logic iss_set;
    logic clr_en;
    logic busy_a1;
    logic busy_a2;
    logic iss_free;

    assign alu_req  = bus.alu_we & (bus.alu_rd != ZERO_REG);
    assign alu_take = alu_req & (state != FORCE);
    assign lu_ready = bus.lu_valid & ~alu_take;
    assign lu_write = lu_ready & (bus.lu_rd != ZERO_REG);

    assign bus.lu_ready  = lu_ready;
    assign bus.alu_stall = (state == FORCE) & alu_req;

    assign iss_set = bus.iss_valid & iss_free
                   & (bus.iss_rd != ZERO_REG);
    assign bus.iss_ready = iss_free;

    // Release busy only when the LU result actually commits to the RF.
    assign clr_en = bus.rf_we & rf_src_lu;

    assign bus.raw_hazard = busy_a1 | busy_a2;

    rf_scoreboard u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (iss_set),
        .set_addr (bus.iss_rd),
        .clr_en   (clr_en),
        .clr_addr (bus.rf_a3),
        .rd_a1    (bus.chk_a1),
        .rd_a2    (bus.chk_a2),
        .iss_rd   (bus.iss_rd),
        .busy_a1  (busy_a1),
        .busy_a2  (busy_a2),
        .iss_free (iss_free),
        .busy     (busy_vec)
    );

    // Starvation guard: count blocked LU cycles, then lock out the ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.lu_valid && !lu_ready) begin
                        if (CNT_LAST == 4'd0) begin
                            state    <= FORCE;
                            wait_cnt <= '0;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (lu_ready || !bus.lu_valid) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt >= CNT_LAST) begin
                        state    <= FORCE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                FORCE: begin
                    if (lu_ready || !bus.lu_valid) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Registered write port: the cycle's winner drives the RF next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rf_we <= 1'b0;
            bus.rf_a3 <= '0;
            bus.rf_wd <= '0;
            rf_src_lu <= 1'b0;
        end else if (alu_take) begin
            bus.rf_we <= 1'b1;
            bus.rf_a3 <= bus.alu_rd;
            bus.rf_wd <= bus.alu_wd;
            rf_src_lu <= 1'b0;
        end else if (lu_write) begin
            bus.rf_we <= 1'b1;
            bus.rf_a3 <= bus.lu_rd;
            bus.rf_wd <= bus.lu_wd;
            rf_src_lu <= 1'b1;
        end else begin
            bus.rf_we <= 1'b0;
            rf_src_lu <= 1'b0;
        end
    end

    // Sticky flag: ALU overwrote a register still owed by the LU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.err_waw <= 1'b0;
        else if (alu_take && busy_vec[bus.alu_rd])
            bus.err_waw <= 1'b1;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: RF writes are predicted into a queue
// as stimulus is driven and popped when the write port should fire.
import rf_wb_arbiter_pkg::*;

module tb_rf_wb_arbiter;

    logic clk;
    logic reset_n;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  a3;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  cyc     = 0;
    int  vectors = 0;
    int  errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.due = cyc + 1;
        e.a3  = a;
        e.wd  = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rf_we", 32'(bus.rf_we), 32'd1);
            chk("rf_a3", 32'(bus.rf_a3), 32'(e.a3));
            chk("rf_wd", bus.rf_wd, e.wd);
        end else begin
            chk("rf_quiet", 32'(bus.rf_we), 32'd0);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.alu_we    = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_wd    = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_wd     = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.chk_a1    = '0;
        bus.chk_a2    = '0;

        #2;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_a3", 32'(bus.rf_a3), 32'd0);
        chk("rst_rf_wd", bus.rf_wd, 32'd0);
        chk("rst_err", 32'(bus.err_waw), 32'd0);
        chk("rst_raw", 32'(bus.raw_hazard), 32'd0);
        #10;
        reset_n = 1'b1;

        // ALU write appears one cycle later
        bus.alu_we = 1'b1;
        bus.alu_rd = 5'd5;
        bus.alu_wd = 32'hDEADBEEF;
        #1;
        chk("alu_lu_ready", 32'(bus.lu_ready), 32'd0);
        chk("alu_stall0", 32'(bus.alu_stall), 32'd0);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        bus.alu_we = 1'b0;

        // Scoreboard set, hazard, LU clear
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        #1;
        chk("iss_ready7", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.iss_valid = 1'b0;
        bus.chk_a1    = 5'd7;
        #1;
        chk("raw7", 32'(bus.raw_hazard), 32'd1);
        chk("iss_busy7", 32'(bus.iss_ready), 32'd0);
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd7;
        bus.lu_wd    = 32'h11;
        #1;
        chk("lu_acc7", 32'(bus.lu_ready), 32'd1);
        expect_wr(5'd7, 32'h11);
        tick();
        bus.lu_valid = 1'b0;
        #1;
        chk("raw7_commit", 32'(bus.raw_hazard), 32'd1);
        tick();
        chk("raw7_clr", 32'(bus.raw_hazard), 32'd0);
        chk("iss_ready7b", 32'(bus.iss_ready), 32'd1);
        bus.chk_a1 = '0;

        // Starvation guard with MAX_WAIT=4
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd12;
        bus.lu_wd    = 32'hA5A5;
        bus.alu_we   = 1'b1;
        bus.alu_rd   = 5'd4;
        for (int i = 0; i < 4; i++) begin
            bus.alu_wd = 32'h100 + 32'(i);
            #1;
            chk("starve_lu_ready", 32'(bus.lu_ready), 32'd0);
            chk("starve_stall", 32'(bus.alu_stall), 32'd0);
            expect_wr(5'd4, 32'h100 + 32'(i));
            tick();
        end
        #1;
        chk("force_stall", 32'(bus.alu_stall), 32'd1);
        chk("force_lu_ready", 32'(bus.lu_ready), 32'd1);
        expect_wr(5'd12, 32'hA5A5);
        tick();
        bus.lu_valid = 1'b0;
        bus.alu_wd   = 32'h200;
        #1;
        chk("post_force_stall", 32'(bus.alu_stall), 32'd0);
        expect_wr(5'd4, 32'h200);
        tick();

        // ALU to x0 does not block the LU
        bus.alu_rd   = 5'd0;
        bus.alu_wd   = 32'h55;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd13;
        bus.lu_wd    = 32'h77;
        #1;
        chk("x0_lu_ready", 32'(bus.lu_ready), 32'd1);
        chk("x0_stall", 32'(bus.alu_stall), 32'd0);
        expect_wr(5'd13, 32'h77);
        tick();
        bus.alu_we = 1'b0;

        // LU result to x0: accepted, no write
        bus.lu_rd = 5'd0;
        bus.lu_wd = 32'h99;
        #1;
        chk("lu_x0_ready", 32'(bus.lu_ready), 32'd1);
        tick();
        bus.lu_valid = 1'b0;

        // x0 is never tracked
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        #1;
        chk("iss_x0", 32'(bus.iss_ready), 32'd1);
        tick();
        chk("raw_x0", 32'(bus.raw_hazard), 32'd0);

        // WAW error: ALU writes busy x9
        bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        bus.chk_a2    = 5'd9;
        bus.alu_we    = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_wd    = 32'hCAFE;
        #1;
        chk("raw9", 32'(bus.raw_hazard), 32'd1);
        chk("waw_pre", 32'(bus.err_waw), 32'd0);
        expect_wr(5'd9, 32'hCAFE);
        tick();
        bus.alu_we = 1'b0;
        chk("waw_set", 32'(bus.err_waw), 32'd1);
        tick();
        chk("waw_sticky", 32'(bus.err_waw), 32'd1);
        bus.chk_a2 = '0;

        // Async reset while in WAIT with x3 busy
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd3;
        tick();
        bus.iss_valid = 1'b0;
        bus.lu_valid  = 1'b1;
        bus.lu_rd     = 5'd3;
        bus.lu_wd     = 32'h33;
        bus.alu_we    = 1'b1;
        bus.alu_rd    = 5'd6;
        bus.alu_wd    = 32'h66;
        #1;
        chk("rw_lu_ready", 32'(bus.lu_ready), 32'd0);
        expect_wr(5'd6, 32'h66);
        tick();
        bus.chk_a1 = 5'd3;
        #1;
        chk("rw_raw3", 32'(bus.raw_hazard), 32'd1);
        chk("rw_iss3", 32'(bus.iss_ready), 32'd0);
        chk("rw_state", 32'(dut.state), 32'(WAIT));
        reset_n = 1'b0;
        #1;
        chk("ar_rf_we", 32'(bus.rf_we), 32'd0);
        chk("ar_rf_a3", 32'(bus.rf_a3), 32'd0);
        chk("ar_rf_wd", bus.rf_wd, 32'd0);
        chk("ar_err", 32'(bus.err_waw), 32'd0);
        chk("ar_raw", 32'(bus.raw_hazard), 32'd0);
        chk("ar_iss3", 32'(bus.iss_ready), 32'd1);
        chk("ar_state", 32'(dut.state), 32'(IDLE));
        chk("ar_cnt", 32'(dut.wait_cnt), 32'd0);
        bus.lu_valid = 1'b0;
        bus.alu_we   = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_iss3", 32'(bus.iss_ready), 32'd1);
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port (A3/WD3/WE) of the 32x32 register file.
- Shares that port between two writeback sources:
  - the in-order ALU pipeline (priority source);
  - a long-latency unit (multiply/divide or load) using a valid/ready handshake.
- Keeps a per-register scoreboard of outstanding long-latency destinations, so the issue stage can stall on RAW/WAW hazards.
- Has a starvation guard that forces the long-latency unit through after a bounded wait.

Parameters:
- MAX_WAIT, 4, consecutive blocked cycles of a pending long-latency writeback before it is forced through (valid range 1..15).
- XLEN, 32, register data width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_we  in  1  ALU writeback request this cycle.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  XLEN  ALU writeback data.
- alu_stall  out  1  ALU writeback is refused; the pipeline holds its writeback stage.
- lu_valid  in  1  long-latency result available.
- lu_rd  in  5  long-latency destination register.
- lu_wd  in  XLEN  long-latency result data.
- lu_ready  out  1  long-latency result accepted this cycle.
- iss_valid  in  1  issue stage dispatching a long-latency op.
- iss_rd  in  5  destination of that op.
- iss_ready  out  1  dispatch permitted (destination not busy).
- chk_a1  in  5  source register 1 of the instruction in issue.
- chk_a2  in  5  source register 2 of the instruction in issue.
- raw_hazard  out  1  chk_a1 or chk_a2 is busy.
- rf_we  out  1  register file write enable.
- rf_a3  out  5  register file write address.
- rf_wd  out  XLEN  register file write data.
- err_waw  out  1  sticky: ALU wrote a busy register.

Behaviour:
- Reset (asynchronous, reset_n low), all of the following take effect immediately:
  - rf_we=0, rf_a3=0, rf_wd=0.
  - busy[31:0]=0, wait_cnt=0, state=IDLE, err_waw=0, rf_src_lu=0.
- Write port outputs are registered: a winner selected in cycle T appears on rf_* in cycle T+1, and the RF commits at the edge ending T+1.
- A write with rd=0 never asserts rf_we.
- ALU requests with alu_rd=0 are consumed without using the port.
- Arbitration, combinational within the cycle:
  - alu_take = alu_we & (alu_rd!=0) & (state!=FORCE).
  - lu_ready = lu_valid & ~alu_take.
  - alu_stall = (state==FORCE) & alu_we & (alu_rd!=0).
  - At most one source is written per cycle.
- Handshake: lu_valid/lu_rd/lu_wd must hold stable until lu_ready. An LU transfer with lu_rd=0 is accepted with no write.
- FSM states:
  - IDLE → WAIT: lu_valid & ~lu_ready; wait_cnt becomes 1.
  - WAIT → IDLE: on lu_ready; wait_cnt cleared.
  - WAIT → FORCE: blocked with wait_cnt==MAX_WAIT-1; otherwise wait_cnt+1 while blocked.
  - FORCE: lu_ready is guaranteed when lu_valid. FORCE → IDLE on acceptance, or if lu_valid drops (protocol violation, tolerated).
- Scoreboard:
  - Set busy[iss_rd] on iss_valid & iss_ready & iss_rd!=0.
  - iss_ready = ~busy[iss_rd] (x0 is always ready and never tracked).
  - Clear busy[rf_a3] at the edge ending a cycle where rf_we & rf_src_lu. The clear happens when the RF commits, so readers never see stale data with busy=0.
  - Set and clear on the same register in one edge cannot occur, since iss_ready is low while busy. If it did, set wins.
- Hazard check: raw_hazard = busy[chk_a1] | busy[chk_a2]. Combinational, no forwarding.
- err_waw: set when alu_take & busy[alu_rd]; cleared only by reset. The write still proceeds.
- Reset mid-operation: pending LU results are dropped and the scoreboard is cleared. The issue and LU units are reset by the same reset_n.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, the FSM state encoding (IDLE/WAIT/FORCE), and the zero-register index constant.
- One natural sub-module: rf_scoreboard.
  - Contents: 32-bit busy vector, set/clear ports, two read-check ports and an issue check.
  - Reused later by a forwarding unit.

Test Plan:
- After reset, alu_we=1, alu_rd=5, alu_wd=0xDEADBEEF → next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; lu_ready=0 throughout.
- iss_valid=1, iss_rd=7 → busy[7]=1; then chk_a1=7 → raw_hazard=1, and iss_rd=7 → iss_ready=0. After lu_valid with lu_rd=7, lu_wd=0x11 is accepted: rf write one cycle later, raw_hazard drops the cycle after that.
- lu_valid=1 and alu_we=1 every cycle with MAX_WAIT=4:
  - lu_ready=0 for 4 cycles, then state FORCE, alu_stall=1 and lu_ready=1.
  - The next cycle has rf_a3=lu_rd, then state IDLE and alu_stall=0.
- alu_we=1, alu_rd=0 while lu_valid=1 → lu_ready=1 in the same cycle; no rf write for the ALU.
- busy[9] set, then ALU writes rd=9 → err_waw=1 and stays 1; rf write of the ALU data still occurs.
- reset_n pulsed low while in WAIT with busy[3]=1 → all outputs, busy and state are zero immediately without a clock edge; after release, iss_rd=3 gives iss_ready=1.
